uart_word_link: RTL and testbench

//   Word-level front end for the uart block: drains its RX FIFO and packs

---
 rtl/uart_word_link_if.sv | 31 +++
 rtl/uart_word_link.sv | 141 ++++++++++++++
 tb/tb_uart_word_link.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_link_if.sv
// Signal bundle between uart_word_link, the uart byte FIFOs and the word-level host.
// master = the word link itself, slave = everything around it (uart + host).
interface uart_word_link_if #(
    parameter int DBIT       = 8,
    parameter int WORD_BYTES = 4
);
    localparam int W = DBIT * WORD_BYTES;

    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            rd_uart;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic            tx_done_tick;
    logic [W-1:0]    rx_word;
    logic            rx_word_valid;
    logic            rx_overrun;
    logic [W-1:0]    tx_word;
    logic            tx_word_valid;
    logic            tx_ready;

    modport master (
        input  rx_empty, r_data, tx_done_tick, tx_word, tx_word_valid,
        output rd_uart, wr_uart, w_data, rx_word, rx_word_valid, rx_overrun, tx_ready
    );

    modport slave (
        output rx_empty, r_data, tx_done_tick, tx_word, tx_word_valid,
        input  rd_uart, wr_uart, w_data, rx_word, rx_word_valid, rx_overrun, tx_ready
    );
endinterface

// File: rtl/uart_word_link.sv
// Word-level front end for the uart: packs RX bytes into words (LSB first) and
// serialises TX words into byte transmit requests. RX and TX run independently.
module uart_word_link #(
    parameter int DBIT       = 8,
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 1000000,
    parameter int TO_BITS    = 20
) (
    input  logic             clk,
    input  logic             reset,
    uart_word_link_if.master bus
);
    localparam int                 CW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0]      LAST_LANE = CW'(WORD_BYTES - 1);
    localparam logic [TO_BITS-1:0] TO_LIMIT  = TO_BITS'(TIMEOUT);

    typedef logic [WORD_BYTES-1:0][DBIT-1:0] word_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;

    // ---------------- RX path ----------------
    logic               pop;
    logic               pop_q;
    logic [CW-1:0]      byte_cnt;
    word_t              shadow;
    word_t              shadow_next;
    logic [TO_BITS-1:0] to_cnt;
    logic               to_hit;
    word_t              rx_word_q;
    logic               rx_valid_q;
    logic               overrun_q;

    // Registered pop feedback limits the FIFO to one pop every other cycle.
    assign pop    = !bus.rx_empty && !pop_q;
    assign to_hit = (TIMEOUT != 0) && (byte_cnt != '0) && ((to_cnt + 1'b1) == TO_LIMIT);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        shadow_next           = shadow;
        shadow_next[byte_cnt] = bus.r_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q      <= 1'b0;
            byte_cnt   <= '0;
            shadow     <= '0;
            to_cnt     <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pop_q      <= pop;
            rx_valid_q <= 1'b0;
            if (pop) begin
                shadow <= shadow_next;
                to_cnt <= '0;
                if (byte_cnt == LAST_LANE) begin
                    byte_cnt   <= '0;
                    rx_word_q  <= shadow_next;
                    rx_valid_q <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_cnt != '0) begin
                // Stale partial word: drop it; lanes are overwritten by the next word.
                if (to_hit) begin
                    byte_cnt  <= '0;
                    to_cnt    <= '0;
                    overrun_q <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ---------------- TX path ----------------
    tx_state_t       tx_state;
    word_t           tx_buf;
    logic [CW-1:0]   idx;
    logic            wr_q;
    logic [DBIT-1:0] w_data_q;
    logic            tx_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            tx_buf     <= '0;
            idx        <= '0;
            wr_q       <= 1'b0;
            w_data_q   <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_word_valid) begin
                        tx_buf     <= bus.tx_word;
                        idx        <= '0;
                        wr_q       <= 1'b1;
                        w_data_q   <= bus.tx_word[DBIT-1:0];
                        tx_ready_q <= 1'b0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    wr_q     <= 1'b0;
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (idx == LAST_LANE) begin
                            tx_ready_q <= 1'b1;
                            tx_state   <= TX_IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            wr_q     <= 1'b1;
                            w_data_q <= tx_buf[idx + 1'b1];
                            tx_state <= TX_START;
                        end
                    end
                end
                default: begin
                    wr_q       <= 1'b0;
                    tx_ready_q <= 1'b1;
                    tx_state   <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_uart       = pop;
    assign bus.rx_word       = rx_word_q;
    assign bus.rx_word_valid = rx_valid_q;
    assign bus.rx_overrun    = overrun_q;
    assign bus.wr_uart       = wr_q;
    assign bus.w_data        = w_data_q;
    assign bus.tx_ready      = tx_ready_q;
endmodule

// File: tb/tb_uart_word_link.sv
// Scoreboard bench for uart_word_link: a uart/FIFO model feeds stimulus, monitors
// on the falling edge pop expected words/bytes from queues and compare.
module tb_uart_word_link;
    localparam int DBIT       = 8;
    localparam int WORD_BYTES = 4;
    localparam int TIMEOUT    = 100;
    localparam int TO_BITS    = 8;
    localparam int TICK_DLY   = 50;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } tx_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_word_link_if #(.DBIT(DBIT), .WORD_BYTES(WORD_BYTES)) bus();

    uart_word_link #(
        .DBIT(DBIT), .WORD_BYTES(WORD_BYTES), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_fifo[$];
    logic [31:0] rx_exp[$];
    tx_exp_t     tx_exp[$];
    tx_exp_t     cur_e;
    bit          cur_last;
    int          cycle = 0;
    int          last_pop = -10;
    bit          will_pop = 0;
    int          busy = 0;
    bit          spurious = 0;
    bit          real_tick = 0;
    bit          chk_ready_next = 0;
    int          wr_count = 0;
    int          pop_count = 0;
    int          rxv_count = 0;

    logic [31:0] rx6[8] = '{32'h01020304, 32'hFFEEDDCC, 32'h00000000, 32'h80000001,
                            32'h13579BDF, 32'h2468ACE0, 32'h5A5AA5A5, 32'hFFFFFFFF};
    logic [31:0] tx6[8] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                            32'h00000001, 32'h80000000, 32'hC0FFEE00, 32'h7E7E7E7E};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh_rx();
        bus.rx_empty = (rx_fifo.size() == 0);
        bus.r_data   = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_fifo.push_back(b);
        refresh_rx();
    endtask

    task automatic send_rx_word(input logic [31:0] w, input int gap_max);
        rx_exp.push_back(w);
        for (int i = 0; i < 4; i++) begin
            push_byte(w[i*8 +: 8]);
            repeat ($urandom_range(gap_max, 0)) step();
        end
    endtask

    task automatic tx_send(input logic [31:0] w);
        int n;
        n = 0;
        bus.tx_word       = w;
        bus.tx_word_valid = 1'b1;
        while (!bus.tx_ready && n < 2000) begin
            step();
            n++;
        end
        check("tx_accept_timeout", n < 2000, 1);
        step();
        bus.tx_word_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_fifo.size() != 0 || rx_exp.size() != 0 || tx_exp.size() != 0 ||
                busy != 0 || !bus.tx_ready) && n < budget) begin
            step();
            n++;
        end
        check({name, "_timeout"}, n < budget, 1);
        repeat (3) step();
    endtask

    task automatic wait_fifo_empty(input string name);
        int n;
        n = 0;
        while (rx_fifo.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, n < 200, 1);
        repeat (2) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_uart"},       bus.rd_uart, 0);
        check({tag, "_wr_uart"},       bus.wr_uart, 0);
        check({tag, "_w_data"},        bus.w_data, 0);
        check({tag, "_rx_word"},       bus.rx_word, 0);
        check({tag, "_rx_word_valid"}, bus.rx_word_valid, 0);
        check({tag, "_rx_overrun"},    bus.rx_overrun, 0);
        check({tag, "_tx_ready"},      bus.tx_ready, 1);
    endtask

    always @(posedge clk) cycle++;

    // uart model: FIFO pops and delayed tx_done_tick, driven just after the edge
    always @(posedge clk) begin
        #1;
        if (will_pop && rx_fifo.size() != 0) void'(rx_fifo.pop_front());
        refresh_rx();
        bus.tx_done_tick = 1'b0;
        real_tick        = 1'b0;
        if (spurious) begin
            bus.tx_done_tick = 1'b1;
            spurious         = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                bus.tx_done_tick = 1'b1;
                real_tick        = 1'b1;
            end
        end
    end

    // monitors / scoreboard
    always @(negedge clk) begin
        will_pop = bus.rd_uart;
        if (bus.rd_uart) begin
            pop_count++;
            check("rd_spacing", (cycle - last_pop) >= 2, 1);
            check("rd_nonempty", rx_fifo.size() != 0, 1);
            last_pop = cycle;
        end
        if (bus.rx_word_valid) begin
            rxv_count++;
            if (rx_exp.size() == 0) check("rx_unexpected_word", bus.rx_word_valid, 0);
            else                    check("rx_word", bus.rx_word, rx_exp.pop_front());
        end
        if (bus.wr_uart) begin
            wr_count++;
            check("wr_while_busy", busy != 0, 0);
            if (tx_exp.size() == 0) begin
                check("tx_unexpected_wr", bus.wr_uart, 0);
            end else begin
                cur_e    = tx_exp.pop_front();
                cur_last = cur_e.last;
                check("w_data", bus.w_data, cur_e.data);
            end
            busy = TICK_DLY;
        end
        if (chk_ready_next) begin
            check("tx_ready_after_last_tick", bus.tx_ready, 1);
            chk_ready_next = 1'b0;
        end
        if (real_tick) begin
            check("tx_ready_while_sending", bus.tx_ready, 0);
            if (cur_last) chk_ready_next = 1'b1;
        end
        if (bus.tx_word_valid && bus.tx_ready) begin
            for (int i = 0; i < 4; i++)
                tx_exp.push_back('{data: bus.tx_word[i*8 +: 8], last: (i == 3)});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        bus.rx_empty      = 1'b1;
        bus.r_data        = '0;
        bus.tx_done_tick  = 1'b0;
        bus.tx_word       = '0;
        bus.tx_word_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) step();

        // 1: one word from four FIFO bytes
        c0 = pop_count;
        c1 = rxv_count;
        send_rx_word(32'h12345678, 0);
        wait_quiet("t1", 200);
        check("t1_pops", pop_count - c0, 4);
        check("t1_valid_pulses", rxv_count - c1, 1);

        // 2: one TX word, ticks 50 cycles after each wr_uart
        c0 = wr_count;
        tx_send(32'hA1B2C3D4);
        wait_quiet("t2", 1000);
        check("t2_wr_pulses", wr_count - c0, 4);

        // 3: partial word timed out, then a full word
        check("t3_overrun_before", bus.rx_overrun, 0);
        c1 = rxv_count;
        push_byte(8'hEE);
        push_byte(8'hFF);
        wait_fifo_empty("t3");
        repeat (TIMEOUT + 50) step();
        check("t3_overrun_set", bus.rx_overrun, 1);
        check("t3_no_partial_valid", rxv_count - c1, 0);
        send_rx_word(32'h44332211, 3);
        wait_quiet("t3", 300);
        check("t3_valid_pulses", rxv_count - c1, 1);
        check("t3_overrun_sticky", bus.rx_overrun, 1);

        // 4: spurious tick while idle, then valid held across two words
        c0 = wr_count;
        spurious = 1'b1;
        repeat (5) step();
        check("t4_spurious_no_wr", wr_count - c0, 0);
        check("t4_idle_ready", bus.tx_ready, 1);
        tx_send(32'hCAFEF00D);
        bus.tx_word       = 32'h0BADBEEF;
        bus.tx_word_valid = 1'b1;
        tx_send(32'h0BADBEEF);
        wait_quiet("t4", 1000);
        check("t4_wr_pulses", wr_count - c0, 8);

        // 5: reset mid RX word and mid TX word
        push_byte(8'h99);
        push_byte(8'h88);
        tx_send(32'h55667788);
        wait_fifo_empty("t5");
        repeat (60) step();
        bus.tx_word_valid = 1'b0;
        reset             = 1'b0;
        tx_exp.delete();
        busy              = 0;
        spurious          = 1'b0;
        chk_ready_next    = 1'b0;
        bus.tx_done_tick  = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        c1 = rxv_count;
        send_rx_word(32'h0F1E2D3C, 2);
        wait_quiet("t5", 300);
        check("t5_valid_pulses", rxv_count - c1, 1);
        check("t5_overrun_clear", bus.rx_overrun, 0);

        // 6: concurrent RX and TX streams
        c0 = wr_count;
        c1 = rxv_count;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rx_word(rx6[i], 20);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    tx_send(tx6[j]);
                    repeat ($urandom_range(10, 0)) step();
                end
            end
        join
        wait_quiet("t6", 5000);
        check("t6_rx_words", rxv_count - c1, 8);
        check("t6_wr_pulses", wr_count - c0, 32);
        check("t6_no_overrun", bus.rx_overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
